// File: rtl/unary_sqrt_mc_if.sv
// unary_sqrt_mc_if: stream/measurement bundle for the multi-channel unary sqrt.
//   en        advance enable (all state holds when low)
//   start     single-cycle frame request
//   rand_num  per-channel trace index, channel c at [c*DEPLOG +: DEPLOG]
//   in        per-channel input bitstream
//   out       per-channel registered sqrt bitstream
//   busy      frame in progress
//   done      one-cycle frame-complete pulse
//   cnt       per-channel ones count of the last frame, channel c at [c*CNTW +: CNTW]
interface unary_sqrt_mc_if #(
    parameter int CH     = 4,
    parameter int DEPLOG = 1,
    parameter int CNTW   = 9
);
    logic                   en;
    logic                   start;
    logic [CH*DEPLOG-1:0]   rand_num;
    logic [CH-1:0]          in;
    logic [CH-1:0]          out;
    logic                   busy;
    logic                   done;
    logic [CH*CNTW-1:0]     cnt;

    modport master (output en, start, rand_num, in, input out, busy, done, cnt);
    modport slave  (input en, start, rand_num, in, output out, busy, done, cnt);
endinterface

// File: rtl/unary_sqrt_mc.sv
// unary_sqrt_mc: CH-channel in-stream unipolar square root for unary bitstreams,
// each lane a toggle-gated correlated divider in feedback, plus a framed
// measurement mode counting output ones over LEN enabled cycles.
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   unary_sqrt_mc_if.slave (en, start, rand_num, in -> out, busy, done, cnt)

// One channel: divider datapath and its trace shift register.
//   toggle    shared phase bit
//   idx       raw trace index (saturated here)
//   in_bit    input stream bit
//   out_bit   registered sqrt stream bit
//   out_next  next value of out_bit (feeds the frame accumulator)
module unary_sqrt_lane #(
    parameter int DEP    = 2,
    parameter int DEPLOG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              toggle,
    input  logic [DEPLOG-1:0] idx,
    input  logic              in_bit,
    output logic              out_bit,
    output logic              out_next
);
    logic [DEP-1:0]    tr;
    logic [DEPLOG-1:0] idx_sat;
    logic              dividend, divisor, quotient;

    // Index values past the trace depth read the oldest entry.
    always_comb begin
        idx_sat = idx;
        if (int'(idx) >= DEP) idx_sat = DEPLOG'(DEP - 1);
    end

    assign dividend = ~toggle & out_bit;
    assign divisor  = toggle | dividend;
    // With a zero divisor the quotient is resampled from past quotients,
    // which keeps the output correlated with its own history.
    assign quotient = divisor ? dividend : tr[idx_sat];
    assign out_next = quotient | in_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_bit <= 1'b0;
            for (int i = 0; i < DEP; i++) tr[i] <= ~i[0];
        end else if (en) begin
            out_bit <= out_next;
            if (divisor) begin
                for (int i = DEP - 1; i > 0; i--) tr[i] <= tr[i-1];
                tr[0] <= quotient;
            end
        end
    end
endmodule

module unary_sqrt_mc #(
    parameter int CH     = 4,
    parameter int DEP    = 2,
    parameter int DEPLOG = 1,
    parameter int LEN    = 256,
    parameter int CNTW   = $clog2(LEN + 1)
) (
    input  logic            clk,
    input  logic            rst,
    unary_sqrt_mc_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state;
    logic                    toggle;
    logic                    busy_q, done_q;
    logic [CNTW-1:0]         frame_cnt;
    logic [CH-1:0]           out_q, out_next;
    logic [CH-1:0][CNTW-1:0] acc, acc_next, cnt_q;

    for (genvar c = 0; c < CH; c++) begin : g_lane
        unary_sqrt_lane #(.DEP(DEP), .DEPLOG(DEPLOG)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .en       (bus.en),
            .toggle   (toggle),
            .idx      (bus.rand_num[c*DEPLOG +: DEPLOG]),
            .in_bit   (bus.in[c]),
            .out_bit  (out_q[c]),
            .out_next (out_next[c])
        );
        // Count the value being registered this cycle, so the final edge
        // of a frame can publish acc_next directly.
        assign acc_next[c] = acc[c] + CNTW'(out_next[c]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            toggle    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            frame_cnt <= '0;
            acc       <= '0;
            cnt_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.en) begin
                toggle <= ~toggle;
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state     <= RUN;
                            busy_q    <= 1'b1;
                            frame_cnt <= '0;
                            acc       <= '0;
                        end
                    end
                    RUN: begin
                        acc       <= acc_next;
                        frame_cnt <= frame_cnt + CNTW'(1);
                        if (frame_cnt == CNTW'(LEN - 1)) begin
                            cnt_q  <= acc_next;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.out  = out_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.cnt  = cnt_q;
endmodule

// File: tb/tb_unary_sqrt_mc.sv
// Bench for unary_sqrt_mc: a cycle model of the lanes and frame logic predicts
// out/busy/done/cnt for every driven cycle; predictions go through a scoreboard
// queue and are compared one step later, plus directed frame-level checks.
module tb_unary_sqrt_mc;
    localparam int CH     = 4;
    localparam int DEP    = 3;
    localparam int DEPLOG = 2;
    localparam int LEN    = 256;
    localparam int CNTW   = $clog2(LEN + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    unary_sqrt_mc_if #(.CH(CH), .DEPLOG(DEPLOG), .CNTW(CNTW)) bus ();

    unary_sqrt_mc #(.CH(CH), .DEP(DEP), .DEPLOG(DEPLOG), .LEN(LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [CH-1:0]      out;
        logic               busy;
        logic               done;
        logic [CH*CNTW-1:0] cnt;
    } exp_t;
    exp_t sb[$];

    // model state
    bit                 m_tog;
    bit [DEP-1:0]       m_tr [CH];
    bit [CH-1:0]        m_out;
    bit                 m_run, m_busy, m_done;
    int                 m_fc;
    int                 m_acc [CH];
    bit [CH*CNTW-1:0]   m_cnt;

    int thr [CH];   // per-channel ones threshold out of 256

    function automatic logic [CH-1:0] gen_in();
        logic [CH-1:0] g;
        for (int c = 0; c < CH; c++) g[c] = ($urandom_range(255) < thr[c]);
        return g;
    endfunction

    function automatic logic [CH*DEPLOG-1:0] rnd();
        logic [31:0] v;
        v = $urandom;
        return v[CH*DEPLOG-1:0];
    endfunction

    task automatic step(input bit rs, input bit e, input bit s,
                        input logic [CH-1:0] iv, input logic [CH*DEPLOG-1:0] r);
        exp_t x, y;
        bit [CH-1:0] nxt;
        rst = rs; bus.en = e; bus.start = s; bus.in = iv; bus.rand_num = r;
        nxt = '0;
        if (rs) begin
            m_tog = 0; m_out = '0; m_run = 0; m_busy = 0; m_done = 0; m_fc = 0; m_cnt = '0;
            for (int c = 0; c < CH; c++) begin
                m_acc[c] = 0;
                for (int i = 0; i < DEP; i++) m_tr[c][i] = (i % 2 == 0);
            end
        end else begin
            m_done = 0;
            if (e) begin
                for (int c = 0; c < CH; c++) begin
                    int k;
                    bit dvd, dvs, q;
                    k = int'(r[c*DEPLOG +: DEPLOG]);
                    if (k >= DEP) k = DEP - 1;
                    dvd = !m_tog && m_out[c];
                    dvs = m_tog || dvd;
                    q   = dvs ? dvd : m_tr[c][k];
                    nxt[c] = q | iv[c];
                    if (dvs) m_tr[c] = {m_tr[c][DEP-2:0], q};
                end
                m_tog = !m_tog;
                if (m_run) begin
                    for (int c = 0; c < CH; c++) m_acc[c] += int'(nxt[c]);
                    m_fc++;
                    if (m_fc == LEN) begin
                        m_run = 0; m_busy = 0; m_done = 1;
                        for (int c = 0; c < CH; c++) m_cnt[c*CNTW +: CNTW] = CNTW'(m_acc[c]);
                    end
                end else if (s) begin
                    m_run = 1; m_busy = 1; m_fc = 0;
                    for (int c = 0; c < CH; c++) m_acc[c] = 0;
                end
                m_out = nxt;
            end
        end
        x.out = m_out; x.busy = m_busy; x.done = m_done; x.cnt = m_cnt;
        sb.push_back(x);
        @(posedge clk);
        #1;
        y = sb.pop_front();
        chk("out",  64'(bus.out),  64'(y.out));
        chk("busy", 64'(bus.busy), 64'(y.busy));
        chk("done", 64'(bus.done), 64'(y.done));
        chk("cnt",  64'(bus.cnt),  64'(y.cnt));
    endtask

    // Runs until done (bounded). Counts enabled cycles that began with busy=1.
    task automatic run_frame(input bit stall, input int start_at,
                             output int en_busy, output bit got);
        en_busy = 0;
        got = 0;
        for (int i = 0; i < 4 * LEN && !got; i++) begin
            bit e, b;
            e = stall ? bit'($urandom_range(1)) : 1'b1;
            b = bus.busy;
            if (b && e) en_busy++;
            step(0, e, (i == start_at), gen_in(), rnd());
            got = bus.done;
        end
    endtask

    initial begin
        logic [CH*CNTW-1:0] full;
        int n;
        bit got;
        int c0, c1, c2, c3;

        for (int c = 0; c < CH; c++) full[c*CNTW +: CNTW] = CNTW'(LEN);
        for (int c = 0; c < CH; c++) thr[c] = 256;

        // reset held two cycles with random stimulus
        step(1, 1'($urandom_range(1)), 1'($urandom_range(1)), gen_in(), rnd());
        step(1, 1'($urandom_range(1)), 1'($urandom_range(1)), gen_in(), rnd());
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_cnt",  64'(bus.cnt),  64'd0);

        // trace reset pattern: tr[1]=0, saturated index reads tr[2]=1
        step(0, 1, 0, '0, {CH{2'd1}});
        chk("trace_idx1", 64'(bus.out), 64'd0);
        step(1, 1, 0, '0, '0);
        step(0, 1, 0, '0, {CH{2'd3}});
        chk("trace_sat", 64'(bus.out), 64'hF);
        step(1, 1, 0, '0, '0);

        // saturation: all-ones input, single frame
        step(0, 1, 1, gen_in(), rnd());
        chk("sat_out", 64'(bus.out), 64'hF);
        run_frame(0, -1, n, got);
        chk("sat_done", 64'(got), 64'd1);
        chk("sat_len",  64'(n), 64'(LEN));
        chk("sat_cnt",  64'(bus.cnt), 64'(full));
        step(0, 1, 0, gen_in(), rnd());
        chk("done_pulse", 64'(bus.done), 64'd0);

        // en low holds everything, including a start request
        step(0, 0, 1, gen_in(), rnd());
        chk("en_lo_start", 64'(bus.busy), 64'd0);

        // accuracy: p = 0, 0.25, 0.5625, 1
        thr[0] = 0; thr[1] = 64; thr[2] = 144; thr[3] = 256;
        for (int i = 0; i < 50; i++) step(0, 1, 0, gen_in(), rnd());
        step(0, 1, 1, gen_in(), rnd());
        run_frame(0, -1, n, got);
        chk("acc_done", 64'(got), 64'd1);
        c0 = int'(bus.cnt[0*CNTW +: CNTW]);
        c1 = int'(bus.cnt[1*CNTW +: CNTW]);
        c2 = int'(bus.cnt[2*CNTW +: CNTW]);
        c3 = int'(bus.cnt[3*CNTW +: CNTW]);
        chk("acc_p0", 64'(c0), 64'd0);
        chk("acc_p1", 64'(c3), 64'(LEN));
        chk("acc_mono", 64'(c1 > c0 && c2 > c1 && c3 > c2), 64'd1);

        // stall: random en during the frame
        for (int c = 0; c < CH; c++) thr[c] = 256;
        step(0, 1, 1, gen_in(), rnd());
        run_frame(1, -1, n, got);
        chk("stall_done", 64'(got), 64'd1);
        chk("stall_len",  64'(n), 64'(LEN));
        chk("stall_cnt",  64'(bus.cnt), 64'(full));

        // start mid-frame ignored; start on done cycle accepted
        thr[0] = 128; thr[1] = 32; thr[2] = 200; thr[3] = 0;
        step(0, 1, 1, gen_in(), rnd());
        run_frame(0, 10, n, got);
        chk("ign_done", 64'(got), 64'd1);
        chk("ign_len",  64'(n), 64'(LEN));
        step(0, 1, 1, gen_in(), rnd());
        chk("restart_busy", 64'(bus.busy), 64'd1);

        // reset at frame cycle 100 aborts the frame
        for (int i = 0; i < 100; i++) step(0, 1, 0, gen_in(), rnd());
        chk("pre_rst_busy", 64'(bus.busy), 64'd1);
        step(1, 1, 0, gen_in(), rnd());
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_cnt",  64'(bus.cnt),  64'd0);
        got = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, gen_in(), rnd());
            if (bus.done) got = 1;
        end
        chk("mid_rst_nodone", 64'(got), 64'd0);
        step(0, 1, 1, gen_in(), rnd());
        run_frame(0, -1, n, got);
        chk("post_rst_done", 64'(got), 64'd1);
        chk("post_rst_len",  64'(n), 64'(LEN));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
